// File: rtl/generic_fifo_env_param_ram.sv
// Single-clock FIFO envelope with an internal masked-write 1r1w RAM and a registered read port.
// Supports any depth >= 2, FWFT or registered-read output, threshold flags, flush and high-water mark.
module generic_fifo_env_param_ram #(
  parameter int DAT_WIDTH = 35,
  parameter int DEPTH     = 256,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int AF_LEVEL  = DEPTH-4,
  parameter int AE_LEVEL  = 4,
  parameter bit FWFT      = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 wr_op,
  input  logic [DAT_WIDTH-1:0] wr_data,
  input  logic [DAT_WIDTH-1:0] wr_mask,
  output logic                 full,
  output logic                 almost_full,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   entry_used,
  output logic [PTR_WIDTH:0]   max_used,
  output logic                 wr_full_err,
  input  logic                 rd_op,
  output logic [DAT_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 rd_empty_err
);

  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH-1);
  localparam logic [PTR_WIDTH:0]   DEPTH_C  = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   AF_C     = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0]   AE_C     = (PTR_WIDTH+1)'(AE_LEVEL);

  logic [DAT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, rd_addr;
  logic [PTR_WIDTH:0]   cnt_nxt, max_nxt;
  logic                 push, pop, hazard, vld_nxt, empty_nxt, ram_en;

  assign push = wr_op & ~full & ~clr;
  assign pop  = rd_op & ~empty & ~clr;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    cnt_nxt    = entry_used;
    if (clr) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      cnt_nxt    = '0;
    end else begin
      if (push) wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_nxt = entry_used + 1'b1;
        2'b01:   cnt_nxt = entry_used - 1'b1;
        default: cnt_nxt = entry_used;
      endcase
    end
    // The RAM read of a word written on the same edge returns stale data, so the head waits a cycle.
    hazard    = push && (wr_ptr == rd_ptr_nxt);
    vld_nxt   = FWFT ? (!clr && (cnt_nxt != '0) && !hazard) : pop;
    empty_nxt = FWFT ? !vld_nxt : (cnt_nxt == '0);
    max_nxt   = clr ? '0 : ((cnt_nxt > max_used) ? cnt_nxt : max_used);
    rd_addr   = FWFT ? rd_ptr_nxt : rd_ptr;
    ram_en    = FWFT | pop;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= (mem[wr_ptr] & ~wr_mask) | (wr_data & wr_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (ram_en) begin
      rd_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      entry_used   <= '0;
      max_used     <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_valid     <= 1'b0;
      wr_full_err  <= 1'b0;
      rd_empty_err <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      entry_used   <= cnt_nxt;
      max_used     <= max_nxt;
      full         <= (cnt_nxt == DEPTH_C);
      almost_full  <= (cnt_nxt >= AF_C);
      empty        <= empty_nxt;
      almost_empty <= (cnt_nxt <= AE_C);
      rd_valid     <= vld_nxt;
      wr_full_err  <= wr_op & full & ~clr;
      rd_empty_err <= rd_op & empty & ~clr;
    end
  end

endmodule

// File: tb/tb_generic_fifo_env_param_ram.sv
// Directed bench: a DEPTH=5 FWFT instance and a DEPTH=5 registered-read instance.
module tb_generic_fifo_env_param_ram;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr0 = 0, wr_op0 = 0, rd_op0 = 0;
  logic [7:0] wr_data0 = '0, wr_mask0 = 8'hFF;
  logic       full0, afull0, empty0, aempty0, wr_err0, rd_err0, rd_valid0;
  logic [3:0] used0, max0;
  logic [7:0] rd_data0;
  logic       clr1 = 0, wr_op1 = 0, rd_op1 = 0;
  logic [7:0] wr_data1 = '0, wr_mask1 = 8'hFF;
  logic       full1, afull1, empty1, aempty1, wr_err1, rd_err1, rd_valid1;
  logic [3:0] used1, max1;
  logic [7:0] rd_data1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  generic_fifo_env_param_ram #(.DAT_WIDTH(8), .DEPTH(5), .PTR_WIDTH(3), .AF_LEVEL(1),
                               .AE_LEVEL(4), .FWFT(1'b1)) u0 (
    .clk(clk), .reset_n(reset_n), .clr(clr0), .wr_op(wr_op0), .wr_data(wr_data0),
    .wr_mask(wr_mask0), .full(full0), .almost_full(afull0), .empty(empty0),
    .almost_empty(aempty0), .entry_used(used0), .max_used(max0), .wr_full_err(wr_err0),
    .rd_op(rd_op0), .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_empty_err(rd_err0));

  generic_fifo_env_param_ram #(.DAT_WIDTH(8), .DEPTH(5), .PTR_WIDTH(3), .AF_LEVEL(1),
                               .AE_LEVEL(4), .FWFT(1'b0)) u1 (
    .clk(clk), .reset_n(reset_n), .clr(clr1), .wr_op(wr_op1), .wr_data(wr_data1),
    .wr_mask(wr_mask1), .full(full1), .almost_full(afull1), .empty(empty1),
    .almost_empty(aempty1), .entry_used(used1), .max_used(max1), .wr_full_err(wr_err1),
    .rd_op(rd_op1), .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_empty_err(rd_err1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q [5];
    exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44; exp_q[4] = 8'h55;

    step; step;
    reset_n = 1'b1;
    chk("rst_empty", empty0, 1);
    chk("rst_aempty", aempty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_afull", afull0, 0);
    chk("rst_used", used0, 0);
    chk("rst_rd_data", rd_data0, 0);
    chk("rst_rd_valid", rd_valid0, 0);
    chk("rst_empty1", empty1, 1);
    chk("rst_rd_data1", rd_data1, 0);

    // fill to full, then an overflowing push
    for (int i = 0; i < 5; i++) begin
      wr_op0 = 1; wr_data0 = exp_q[i];
      step;
      if (i == 0) chk("fwft_bubble_c1", empty0, 1);
      if (i == 1) chk("fwft_empty_fall_c2", empty0, 0);
    end
    chk("fill_full", full0, 1);
    chk("fill_used", used0, 5);
    chk("fill_afull", afull0, 1);
    chk("fill_aempty", aempty0, 0);
    chk("fill_max", max0, 5);
    chk("fill_head", rd_data0, 8'h11);
    wr_data0 = 8'h66; rd_op0 = 0;
    step;
    wr_op0 = 0;
    chk("ovf_err", wr_err0, 1);
    chk("ovf_used", used0, 5);
    step;
    chk("ovf_err_pulse", wr_err0, 0);

    // back-to-back pops
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("pop_data%0d", i), rd_data0, exp_q[i]);
      chk($sformatf("pop_valid%0d", i), rd_valid0, 1);
      rd_op0 = 1;
      step;
    end
    chk("drain_empty", empty0, 1);
    chk("drain_used", used0, 0);
    step;
    rd_op0 = 0;
    chk("udf_err", rd_err0, 1);
    step;
    chk("udf_err_pulse", rd_err0, 0);

    // wrap-around with two entries in flight
    wr_op0 = 1; wr_data0 = 8'h80; step;
    wr_data0 = 8'h81; step;
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("wrap_data%0d", i), rd_data0, 8'h80 + i);
      chk($sformatf("wrap_used%0d", i), used0, 2);
      wr_op0 = 1; wr_data0 = 8'h82 + 8'(i); rd_op0 = 1;
      step;
    end
    wr_op0 = 0; rd_op0 = 0;
    chk("wrap_tail_data", rd_data0, 8'h8D);
    chk("wrap_tail_used", used0, 2);

    // flush wins over a concurrent push
    wr_op0 = 1; wr_data0 = 8'h99; step;
    chk("pre_clr_used", used0, 3);
    clr0 = 1; wr_data0 = 8'hEE; step;
    clr0 = 0; wr_op0 = 0;
    chk("clr_used", used0, 0);
    chk("clr_max", max0, 0);
    chk("clr_empty", empty0, 1);
    chk("clr_aempty", aempty0, 1);
    step;
    chk("clr_push_dropped", used0, 0);
    chk("clr_still_empty", empty0, 1);

    // same-address hazard bubble
    wr_op0 = 1; wr_data0 = 8'h5A; step;
    wr_op0 = 0; step;
    chk("hz_head", rd_data0, 8'h5A);
    chk("hz_used1", used0, 1);
    wr_op0 = 1; wr_data0 = 8'hA5; rd_op0 = 1; step;
    wr_op0 = 0; rd_op0 = 0;
    chk("hz_bubble_empty", empty0, 1);
    chk("hz_bubble_used", used0, 1);
    step;
    chk("hz_after_empty", empty0, 0);
    chk("hz_after_data", rd_data0, 8'hA5);

    // asynchronous reset mid-stream
    wr_op0 = 1; wr_data0 = 8'h77; step;
    wr_op0 = 0;
    chk("pre_arst_used", used0, 2);
    #2 reset_n = 0;
    #1;
    chk("arst_used", used0, 0);
    chk("arst_empty", empty0, 1);
    chk("arst_rd_data", rd_data0, 0);
    chk("arst_max", max0, 0);
    chk("arst_rd_valid", rd_valid0, 0);
    step;
    reset_n = 1;

    // registered-read mode with masked write
    wr_op1 = 1; wr_data1 = 8'hFF; wr_mask1 = 8'hFF; step;
    wr_op1 = 0;
    chk("rr_empty_fall_c1", empty1, 0);
    chk("rr_used", used1, 1);
    chk("rr_no_valid", rd_valid1, 0);
    rd_op1 = 1; step;
    rd_op1 = 0;
    chk("rr_valid", rd_valid1, 1);
    chk("rr_data", rd_data1, 8'hFF);
    step;
    chk("rr_valid_pulse", rd_valid1, 0);
    chk("rr_data_hold", rd_data1, 8'hFF);
    clr1 = 1; step;
    clr1 = 0;
    chk("rr_clr_used", used1, 0);
    wr_op1 = 1; wr_data1 = 8'h00; wr_mask1 = 8'h0F; step;
    wr_op1 = 0; rd_op1 = 1; step;
    rd_op1 = 0;
    chk("mask_valid", rd_valid1, 1);
    chk("mask_data", rd_data1, 8'hF0);
    step;
    chk("mask_valid_pulse", rd_valid1, 0);
    chk("mask_empty", empty1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
